// File: rtl/bht_pkg.sv
// Shared counter constants and the saturating counter step for the branch history table.
package bht_pkg;

  // Weakly not-taken: 2^(w-1)-1
  function automatic logic [31:0] ctr_reset_val(input int unsigned w);
    return (32'(1) << (w - 1)) - 32'(1);
  endfunction

  // Weakly taken: 2^(w-1)
  function automatic logic [31:0] ctr_alloc_val(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

  // Saturates at 0 and 2^w-1; simultaneous inc and dec hold the value.
  function automatic logic [31:0] ctr_step(input logic [31:0] cnt, input logic inc,
                                           input logic dec, input int unsigned w);
    logic [31:0] max_v;
    max_v = (32'(1) << w) - 32'(1);
    if (inc && !dec && (cnt != max_v)) return cnt + 32'(1);
    if (dec && !inc && (cnt != 32'(0))) return cnt - 32'(1);
    return cnt;
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// One saturating prediction counter; synchronous active-low reset to weakly not-taken.
module bht_sat_counter
  import bht_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [CTR_W-1:0] load_val,
  output logic [CTR_W-1:0] count
);

  always_ff @(posedge clk_i) begin
    if (!rst_i)    count <= CTR_W'(ctr_reset_val(CTR_W));
    else if (load) count <= load_val;
    else           count <= CTR_W'(ctr_step(32'(count), inc, dec, CTR_W));
  end

endmodule

// File: rtl/bht_predictor.sv
// Direct-mapped branch history table; optional tag/target store enabled by BHT_BTB_EN.
module bht_predictor
  import bht_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned CTR_W   = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            predict_hit_o,
  output logic            predict_taken_o,
  output logic [XLEN-1:0] predict_target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            invalidate_i
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = XLEN - IDX_W - 2;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] up_idx;
  logic [CTR_W-1:0] count [ENTRIES];
  logic             ctr_inc;
  logic             ctr_dec;
  logic             ctr_load;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign up_idx = upd_pc_i[IDX_W+1:2];

  // Counter controls are broadcast; only the entry addressed by the update acts on them.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_ctr
    logic sel;
    assign sel = (up_idx == IDX_W'(e));
    bht_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .inc      (sel && ctr_inc),
      .dec      (sel && ctr_dec),
      .load     (sel && ctr_load),
      .load_val (CTR_W'(ctr_alloc_val(CTR_W))),
      .count    (count[e])
    );
  end

`ifdef BHT_BTB_EN
  logic [TAG_W-1:0]   lk_tag;
  logic [TAG_W-1:0]   up_tag;
  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_mem [ENTRIES];
  logic [XLEN-1:0]    tgt_mem [ENTRIES];
  logic               upd_fire;
  logic               upd_hit;
  logic               lk_hit;
  logic               unused_bits;

  assign lk_tag      = lookup_pc_i[XLEN-1:IDX_W+2];
  assign up_tag      = upd_pc_i[XLEN-1:IDX_W+2];
  assign unused_bits = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  // Invalidate wins over a same-cycle update.
  assign upd_fire = upd_valid_i && !invalidate_i;
  assign upd_hit  = valid[up_idx] && (tag_mem[up_idx] == up_tag);
  assign ctr_inc  = upd_fire && upd_hit && upd_taken_i;
  assign ctr_dec  = upd_fire && upd_hit && !upd_taken_i;
  assign ctr_load = upd_fire && !upd_hit && upd_taken_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_mem[i] <= '0;
        tgt_mem[i] <= '0;
      end
    end else if (invalidate_i) begin
      valid <= '0;
    end else if (upd_valid_i && upd_taken_i) begin
      if (!upd_hit) begin
        valid[up_idx]   <= 1'b1;
        tag_mem[up_idx] <= up_tag;
      end
      tgt_mem[up_idx] <= upd_target_i;
    end
  end

  assign lk_hit           = valid[lk_idx] && (tag_mem[lk_idx] == lk_tag);
  assign predict_hit_o    = lk_hit;
  assign predict_taken_o  = lk_hit && count[lk_idx][CTR_W-1];
  assign predict_target_o = lk_hit ? tgt_mem[lk_idx] : '0;
`else
  logic unused_bits;

  assign unused_bits = ^{lookup_pc_i[XLEN-1:IDX_W+2], lookup_pc_i[1:0],
                         upd_pc_i[XLEN-1:IDX_W+2], upd_pc_i[1:0],
                         upd_target_i, invalidate_i};

  // Counter-only table: every resolved branch trains its counter.
  assign ctr_inc  = upd_valid_i && upd_taken_i;
  assign ctr_dec  = upd_valid_i && !upd_taken_i;
  assign ctr_load = 1'b0;

  assign predict_hit_o    = 1'b1;
  assign predict_taken_o  = count[lk_idx][CTR_W-1];
  assign predict_target_o = '0;
`endif

endmodule

// File: tb/tb_bht_predictor.sv
// Self-checking bench for bht_predictor against a behavioural table model; honours BHT_BTB_EN.
module tb_bht_predictor;

  localparam int unsigned ENTRIES  = 16;
  localparam int          CTR_MAX  = 3;
  localparam int          CTR_HALF = 2;
  localparam int          CTR_RST  = 1;
  localparam int          CTR_ALOC = 2;
`ifdef BHT_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] lookup_pc;
  logic        hit;
  logic        taken;
  logic [31:0] target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        invalidate;
  logic        chk_en = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic        m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk_i            (clk),
    .rst_i            (rst_n),
    .lookup_pc_i      (lookup_pc),
    .predict_hit_o    (hit),
    .predict_taken_o  (taken),
    .predict_target_o (target),
    .upd_valid_i      (upd_valid),
    .upd_pc_i         (upd_pc),
    .upd_taken_i      (upd_taken),
    .upd_target_i     (upd_target),
    .invalidate_i     (invalidate)
  );

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(ENTRIES));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'(ENTRIES * 4);
  endfunction

  function automatic int bump(input int c, input logic up);
    if (up) return (c == CTR_MAX) ? CTR_MAX : c + 1;
    return (c == 0) ? 0 : c - 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update at each rising edge
  always @(posedge clk) begin
    int  i;
    bit  mh;
    if (!rst_n) begin
      for (int k = 0; k < ENTRIES; k++) begin
        m_valid[k] <= 1'b0;
        m_tag[k]   <= '0;
        m_tgt[k]   <= '0;
        m_ctr[k]   <= CTR_RST;
      end
    end else begin
      i = idx_of(upd_pc);
      if (BTB) begin
        mh = m_valid[i] && (m_tag[i] == tag_of(upd_pc));
        if (invalidate) begin
          for (int k = 0; k < ENTRIES; k++) m_valid[k] <= 1'b0;
        end else if (upd_valid) begin
          if (mh) begin
            m_ctr[i] <= bump(m_ctr[i], upd_taken);
            if (upd_taken) m_tgt[i] <= upd_target;
          end else if (upd_taken) begin
            m_valid[i] <= 1'b1;
            m_tag[i]   <= tag_of(upd_pc);
            m_tgt[i]   <= upd_target;
            m_ctr[i]   <= CTR_ALOC;
          end
        end
      end else if (upd_valid) begin
        m_ctr[i] <= bump(m_ctr[i], upd_taken);
      end
    end
  end

  // Compare DUT lookup outputs to the model every cycle
  always @(negedge clk) begin
    int          li;
    logic        eh;
    logic        et;
    logic [31:0] etg;
    if (chk_en) begin
      li = idx_of(lookup_pc);
      if (BTB) begin
        eh  = m_valid[li] && (m_tag[li] == tag_of(lookup_pc));
        et  = eh && (m_ctr[li] >= CTR_HALF);
        etg = eh ? m_tgt[li] : 32'd0;
      end else begin
        eh  = 1'b1;
        et  = (m_ctr[li] >= CTR_HALF);
        etg = 32'd0;
      end
      check("hit", 32'(hit), 32'(eh));
      check("taken", 32'(taken), 32'(et));
      check("target", target, etg);
    end
  end

  task automatic drive(input logic r, input logic uv, input logic [31:0] upc, input logic ut,
                       input logic [31:0] utg, input logic inv, input logic [31:0] lpc);
    @(posedge clk);
    #2;
    rst_n      = r;
    upd_valid  = uv;
    upd_pc     = upc;
    upd_taken  = ut;
    upd_target = utg;
    invalidate = inv;
    lookup_pc  = lpc;
  endtask

  task automatic expect_out(input string name, input logic eh, input logic et,
                            input logic [31:0] etg);
    @(negedge clk);
    check({name, "_hit"}, 32'(hit), 32'(eh));
    check({name, "_taken"}, 32'(taken), 32'(et));
    check({name, "_target"}, target, etg);
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    // Reset with an update presented that must be discarded
    rst_n = 1'b0; upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
    upd_target = 32'h200; invalidate = 1'b1; lookup_pc = 32'h100;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;
    drive(1, 0, 0, 0, 0, 0, 32'h100);
    expect_out("reset", !BTB, 1'b0, 32'h0);

    // Allocate 0x40
    drive(1, 1, 32'h40, 1, 32'h80, 0, 32'h40);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    expect_out("alloc", 1'b1, 1'b1, BTB ? 32'h80 : 32'h0);
    check("alloc_ctr", 32'(m_ctr[0]), 32'd2);

    // Saturation up then down
    repeat (4) drive(1, 1, 32'h40, 1, 32'h80, 0, 32'h40);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    check("sat_hi_ctr", 32'(m_ctr[0]), 32'd3);
    repeat (2) drive(1, 1, 32'h40, 0, 32'h0, 0, 32'h40);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    expect_out("sat_lo", 1'b1, 1'b0, BTB ? 32'h80 : 32'h0);
    check("sat_lo_ctr", 32'(m_ctr[0]), 32'd1);

    // Same-cycle lookup sees pre-update counter
    drive(1, 1, 32'h40, 1, 32'h80, 0, 32'h40);
    expect_out("nobypass", 1'b1, 1'b0, BTB ? 32'h80 : 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    expect_out("after_upd", 1'b1, 1'b1, BTB ? 32'h80 : 32'h0);
    check("after_upd_ctr", 32'(m_ctr[0]), 32'd2);

    // Alias: 0x80 shares index 0 with 0x40
    drive(1, 1, 32'h80, 1, 32'hC0, 0, 32'h80);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    expect_out("alias_old", !BTB, !BTB, 32'h0);
    drive(1, 0, 0, 0, 0, 0, 32'h80);
    expect_out("alias_new", 1'b1, 1'b1, BTB ? 32'hC0 : 32'h0);
    check("alias_ctr", 32'(m_ctr[0]), BTB ? 32'd2 : 32'd3);

    // Invalidate together with an update
    drive(1, 1, 32'h40, 1, 32'h44, 0, 32'h40);
    drive(1, 1, 32'h40, 0, 32'h0, 1, 32'h40);
    drive(1, 0, 0, 0, 0, 0, 32'h40);
    expect_out("inval", !BTB, !BTB, 32'h0);
    check("inval_ctr", 32'(m_ctr[0]), 32'd2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), rand_pc(),
            ($urandom_range(0, 2) != 0), $urandom(), ($urandom_range(0, 39) == 0), rand_pc());
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
